// File: rtl/traffic_pkg.sv
// Shared definitions for the junction phase scheduler.
// Holds the lamp codes driven per approach, the controller state encoding
// (also exported on the debug phase output) and the default phase timings.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        CLEAR  = 3'd3,
        PED    = 3'd4,
        EMG    = 3'd5
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MIN_GREEN   = 40;
    localparam int DEF_MAX_GREEN   = 120;
    localparam int DEF_YELLOW_TIME = 20;
    localparam int DEF_CLEAR_TIME  = 10;
    localparam int DEF_PED_TIME    = 40;
    localparam int DEF_EMG_MAX     = 200;

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter for vehicle demand.
// Searches upward from the approach after i_last, wrapping, so the approach
// served most recently has the lowest priority.
//   i_req         : demand per approach
//   i_last        : approach granted most recently
//   o_grant_dir   : winning approach
//   o_grant_valid : at least one request is present
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_grant_dir,
    output logic       o_grant_valid
);

    logic [1:0] w_cand;

    // Walk candidates from farthest to nearest so the nearest requester
    // after i_last overwrites the others; offset 4 wraps back to i_last.
    always_comb begin
        o_grant_dir   = '0;
        o_grant_valid = 1'b0;
        w_cand        = '0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = i_last + 2'(k);
            if (i_req[w_cand]) begin
                o_grant_dir   = w_cand;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Four-approach intersection phase scheduler (N=0, E=1, S=2, W=3).
// Sequences approaches through green, yellow and all-red clearance with
// round-robin service, min/max green timing, one pedestrian phase and
// emergency pre-emption. Lamp outputs are a decode of registered state.
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_veh_req    : level vehicle demand per approach
//   i_ped_button : pedestrian request
//   i_emg_req    : emergency pre-emption request (level)
//   i_emg_dir    : approach requested by the emergency, sampled on acceptance
//   o_lights     : lamp code for approach i at [3i+2:3i]
//   o_ped_light  : walk lamp
//   o_emg_light  : emergency indicator
//   o_active_dir : approach owning green/yellow/emergency
//   o_phase      : current state encoding
module junction_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MIN_GREEN   = CNT_W'(DEF_MIN_GREEN),
    parameter logic [CNT_W-1:0] MAX_GREEN   = CNT_W'(DEF_MAX_GREEN),
    parameter logic [CNT_W-1:0] YELLOW_TIME = CNT_W'(DEF_YELLOW_TIME),
    parameter logic [CNT_W-1:0] CLEAR_TIME  = CNT_W'(DEF_CLEAR_TIME),
    parameter logic [CNT_W-1:0] PED_TIME    = CNT_W'(DEF_PED_TIME),
    parameter logic [CNT_W-1:0] EMG_MAX     = CNT_W'(DEF_EMG_MAX)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_veh_req,
    input  logic        i_ped_button,
    input  logic        i_emg_req,
    input  logic [1:0]  i_emg_dir,
    output logic [11:0] o_lights,
    output logic        o_ped_light,
    output logic        o_emg_light,
    output logic [1:0]  o_active_dir,
    output logic [2:0]  o_phase
);

    localparam logic [CNT_W-1:0] MIN_LAST = MIN_GREEN - CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_LAST = MAX_GREEN - CNT_W'(1);
    localparam logic [CNT_W-1:0] YEL_LAST = YELLOW_TIME - CNT_W'(1);
    localparam logic [CNT_W-1:0] CLR_LAST = CLEAR_TIME - CNT_W'(1);
    localparam logic [CNT_W-1:0] PED_LAST = PED_TIME - CNT_W'(1);
    localparam logic [CNT_W-1:0] EMG_LAST = EMG_MAX - CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_active_dir;
    logic [1:0]       r_last_dir;
    logic             r_ped_pending;
    logic             r_emg_armed;
    logic             r_emg_pending;
    logic [1:0]       r_emg_target;
    logic [CNT_W-1:0] r_cnt;

    state_t     w_next_state;
    logic [1:0] w_next_dir;
    state_t     w_d_state;
    logic [1:0] w_d_dir;
    logic       w_emg_accept;
    logic [1:0] w_emg_dir_eff;
    logic       w_own_req;
    logic       w_other_dem;
    logic [1:0] w_grant_dir;
    logic       w_grant_valid;
    logic [2:0] w_lamp;

    rr_arbiter4 u_arb (
        .i_req         (i_veh_req),
        .i_last        (r_last_dir),
        .o_grant_dir   (w_grant_dir),
        .o_grant_valid (w_grant_valid)
    );

    // Acceptance is blocked inside EMG so a running pre-emption cannot be
    // retargeted; a request accepted this cycle uses the live direction
    // because emg_target has not been loaded yet.
    assign w_emg_accept  = i_emg_req && r_emg_armed && (r_state != EMG);
    assign w_emg_dir_eff = w_emg_accept ? i_emg_dir : r_emg_target;
    assign w_own_req     = i_veh_req[r_active_dir];
    assign w_other_dem   = (|(i_veh_req & ~dir_onehot(r_active_dir))) || r_ped_pending;

    // Next-state logic; the shared decision (emergency, then pedestrian,
    // then vehicle, else idle) is computed once and used by IDLE and CLEAR.
    always_comb begin
        w_next_state = r_state;
        w_next_dir   = r_active_dir;
        w_d_state    = IDLE;
        w_d_dir      = r_active_dir;

        if (w_emg_accept || r_emg_pending) begin
            w_d_state = EMG;
            w_d_dir   = w_emg_dir_eff;
        end else if (r_ped_pending) begin
            w_d_state = PED;
        end else if (w_grant_valid) begin
            w_d_state = GREEN;
            w_d_dir   = w_grant_dir;
        end

        case (r_state)
            IDLE: begin
                w_next_state = w_d_state;
                w_next_dir   = w_d_dir;
            end
            GREEN: begin
                if (w_emg_accept) begin
                    w_next_state = (i_emg_dir == r_active_dir) ? EMG : YELLOW;
                end else if (w_other_dem && (r_cnt >= MIN_LAST) &&
                             (!w_own_req || (r_cnt >= MAX_LAST))) begin
                    w_next_state = YELLOW;
                end
            end
            YELLOW: begin
                if (r_cnt == YEL_LAST) w_next_state = CLEAR;
            end
            CLEAR: begin
                if (r_cnt == CLR_LAST) begin
                    w_next_state = w_d_state;
                    w_next_dir   = w_d_dir;
                end
            end
            PED: begin
                if (w_emg_accept || (r_cnt == PED_LAST)) w_next_state = CLEAR;
            end
            EMG: begin
                if (!i_emg_req || (r_cnt == EMG_LAST)) w_next_state = YELLOW;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, counter and the demand/pre-emption bookkeeping registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_active_dir  <= 2'd0;
            r_last_dir    <= 2'd3;
            r_ped_pending <= 1'b0;
            r_emg_armed   <= 1'b1;
            r_emg_pending <= 1'b0;
            r_emg_target  <= 2'd0;
            r_cnt         <= '0;
        end else begin
            r_state      <= w_next_state;
            r_active_dir <= w_next_dir;

            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((w_next_state == GREEN) && (r_state != GREEN)) begin
                r_last_dir <= w_next_dir;
            end

            if (w_emg_accept) begin
                r_emg_target <= i_emg_dir;
                r_emg_armed  <= 1'b0;
            end else if (!i_emg_req) begin
                r_emg_armed <= 1'b1;
            end

            if (w_next_state == EMG) begin
                r_emg_pending <= 1'b0;
            end else if (w_emg_accept) begin
                r_emg_pending <= 1'b1;
            end

            // A button press coinciding with PED entry is deliberately dropped;
            // an aborted walk is re-queued so it is served after the emergency.
            if ((r_state != PED) && (w_next_state == PED)) begin
                r_ped_pending <= 1'b0;
            end else if ((r_state == PED) && w_emg_accept) begin
                r_ped_pending <= 1'b1;
            end else if ((r_state != PED) && i_ped_button) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    // Moore lamp decode: only the active approach leaves red, and only in
    // GREEN, YELLOW or EMG.
    always_comb begin
        w_lamp      = LAMP_RED;
        o_ped_light = 1'b0;
        o_emg_light = 1'b0;
        case (r_state)
            GREEN:   w_lamp = LAMP_GREEN;
            YELLOW:  w_lamp = LAMP_YELLOW;
            EMG: begin
                w_lamp      = LAMP_GREEN;
                o_emg_light = 1'b1;
            end
            PED:     o_ped_light = 1'b1;
            default: w_lamp = LAMP_RED;
        endcase
        o_lights = {4{LAMP_RED}};
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == r_active_dir) o_lights[3*k +: 3] = w_lamp;
        end
    end

    assign o_active_dir = r_active_dir;
    assign o_phase      = r_state;

endmodule
